// File: rtl/mem_loader.sv
// mem_loader: assembles a big-endian byte stream into 16-bit words, loads IRAM then DRAM, then pulses start.
module mem_loader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int IRAM_DEPTH = 256,
  parameter int DRAM_DEPTH = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rearm,
  output logic [DATA_W-1:0] instruc_mem_store,
  output logic              write_en_ir,
  output logic [ADDR_W-1:0] iram_addr,
  output logic [DATA_W-1:0] data_mem_store,
  output logic              write_en_d,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              error
);
  typedef enum logic [3:0] {
    HDR_I_HI, HDR_I_LO, HDR_D_HI, HDR_D_LO, LOAD_I, LOAD_D, START, DONE, ERROR
  } state_t;
  state_t state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       ni_q, ni_d, nd_q, nd_d, idx_q, idx_d;
  logic              lo_q, lo_d, we_ir_q, we_ir_d, we_d_q, we_d_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] ia_q, ia_d, da_q, da_d;
  logic              acc, last;
  assign in_ready = !(state_q inside {START, DONE, ERROR});
  assign acc      = in_valid && in_ready;
  assign last     = (idx_q + 16'd1) == (state_q == LOAD_I ? ni_q : nd_q);
  // START holds off the pulse while the final word's strobe is still on the bus
  assign start    = state_q == START && !(we_ir_q || we_d_q);
  assign busy     = !(state_q inside {DONE, ERROR}) && !start;
  assign done     = state_q == DONE;
  assign error    = state_q == ERROR;
  assign instruc_mem_store = word_q;
  assign data_mem_store    = word_q;
  assign write_en_ir       = we_ir_q;
  assign write_en_d        = we_d_q;
  assign iram_addr         = ia_q;
  assign dram_addr         = da_q;
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    ni_d    = ni_q;
    nd_d    = nd_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    word_d  = word_q;
    ia_d    = ia_q;
    da_d    = da_q;
    we_ir_d = 1'b0;
    we_d_d  = 1'b0;
    case (state_q)
      HDR_I_HI: if (acc) begin
        hi_d    = in_data;
        state_d = HDR_I_LO;
      end
      HDR_I_LO: if (acc) begin
        ni_d    = {hi_q, in_data};
        state_d = HDR_D_HI;
      end
      HDR_D_HI: if (acc) begin
        hi_d    = in_data;
        state_d = HDR_D_LO;
      end
      HDR_D_LO: if (acc) begin
        nd_d    = {hi_q, in_data};
        state_d = (32'(ni_q) > IRAM_DEPTH || 32'(nd_d) > DRAM_DEPTH) ? ERROR :
                  (ni_q != '0) ? LOAD_I : (nd_d != '0) ? LOAD_D : START;
      end
      LOAD_I, LOAD_D: if (acc) begin
        lo_d = !lo_q;
        if (!lo_q) hi_d = in_data;
        else begin
          word_d  = DATA_W'({hi_q, in_data});
          we_ir_d = state_q == LOAD_I;
          we_d_d  = state_q == LOAD_D;
          ia_d    = state_q == LOAD_I ? ADDR_W'(idx_q) : ia_q;
          da_d    = state_q == LOAD_D ? ADDR_W'(idx_q) : da_q;
          idx_d   = last ? 16'd0 : idx_q + 16'd1;
          if (last) state_d = (state_q == LOAD_I && nd_q != '0) ? LOAD_D : START;
        end
      end
      START: state_d = (we_ir_q || we_d_q) ? START : DONE;
      DONE, ERROR: if (rearm) begin
        state_d = HDR_I_HI;
        hi_d    = '0;
        ni_d    = '0;
        nd_d    = '0;
        idx_d   = '0;
        lo_d    = 1'b0;
      end
      default: state_d = HDR_I_HI;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= HDR_I_HI;
      hi_q    <= '0;
      ni_q    <= '0;
      nd_q    <= '0;
      idx_q   <= '0;
      lo_q    <= 1'b0;
      word_q  <= '0;
      ia_q    <= '0;
      da_q    <= '0;
      we_ir_q <= 1'b0;
      we_d_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      ni_q    <= ni_d;
      nd_q    <= nd_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      word_q  <= word_d;
      ia_q    <= ia_d;
      da_q    <= da_d;
      we_ir_q <= we_ir_d;
      we_d_q  <= we_d_d;
    end
  end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed scenarios for mem_loader with hand-computed writes, addresses and pulse timing.
module tb_mem_loader;
  logic clock = 1'b0, reset = 1'b0, in_valid = 1'b0, rearm = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, write_en_ir, write_en_d, start, busy, done, error;
  logic [15:0] instruc_mem_store, data_mem_store, iram_addr, dram_addr;
  mem_loader dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rearm(rearm), .instruc_mem_store(instruc_mem_store), .write_en_ir(write_en_ir),
    .iram_addr(iram_addr), .data_mem_store(data_mem_store), .write_en_d(write_en_d),
    .dram_addr(dram_addr), .start(start), .busy(busy), .done(done), .error(error)
  );
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  int vectors = 0, miscompares = 0;
  logic [15:0] ir_a[64], ir_w[64], dr_a[64], dr_w[64];
  int ir_c[64], dr_c[64], st_c[64];
  int ir_n = 0, dr_n = 0, st_n = 0, both = 0;
  // Strobes and start pulses are logged on the falling edge, tagged with the last rising-edge index
  always @(negedge clock) begin
    if (write_en_ir && ir_n < 64) begin
      ir_a[ir_n] = iram_addr; ir_w[ir_n] = instruc_mem_store; ir_c[ir_n] = cyc; ir_n++;
    end
    if (write_en_d && dr_n < 64) begin
      dr_a[dr_n] = dram_addr; dr_w[dr_n] = data_mem_store; dr_c[dr_n] = cyc; dr_n++;
    end
    if (start && st_n < 64) begin
      st_c[st_n] = cyc; st_n++;
    end
    if (write_en_ir && write_en_d) both++;
  end
  logic [15:0] fw[8];
  int exp_c[8];
  int acc_c, ib, db, sb;
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask
  task automatic send(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    if (gap) begin in_valid = 1'b0; @(posedge clock); #1; end
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin @(posedge clock); #1; n++; end
    if (n == 20) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout byte=%h in_ready=%b required 1", b, in_ready);
    end
    @(posedge clock); #1;
    acc_c = cyc;
    in_valid = 1'b0;
  endtask
  task automatic send_frame(input logic [15:0] ni, input logic [15:0] nd, input int nw, input bit gap);
    logic [15:0] w;
    send(ni[15:8], gap); send(ni[7:0], gap); send(nd[15:8], gap); send(nd[7:0], gap);
    for (int i = 0; i < nw; i++) begin
      w = fw[i];
      send(w[15:8], gap); send(w[7:0], gap);
      exp_c[i] = acc_c;
    end
  endtask
  task automatic pulse_rearm;
    rearm = 1'b1; @(posedge clock); #1; rearm = 1'b0;
  endtask
  task automatic mark;
    ib = ir_n; db = dr_n; sb = st_n;
  endtask
  task automatic test_reset;
    #3 reset = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if ({in_ready, busy, write_en_ir, write_en_d, start, done, error} !== 7'b1100000) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b required=1100000", {in_ready, busy, write_en_ir, write_en_d, start, done, error});
    end
    vectors++;
    if ({instruc_mem_store, data_mem_store, iram_addr, dram_addr} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_buses got=%h required=0", {instruc_mem_store, data_mem_store, iram_addr, dram_addr});
    end
    reset = 1'b0;
    cycles(2);
    vectors++;
    if ({in_ready, busy, start, done, error} !== 5'b11000) begin
      miscompares++;
      $display("FAIL reset_idle got=%b required=11000", {in_ready, busy, start, done, error});
    end
  endtask
  task automatic test_reset_mid_load;
    fw[0] = 16'h1111; fw[1] = 16'h2222; fw[2] = 16'h3333;
    send_frame(16'd4, 16'd0, 3, 1'b0);
    send(8'h44, 1'b0);
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({in_ready, busy, write_en_ir, start, done, error, iram_addr, instruc_mem_store} !== {6'b110000, 32'd0}) begin
      miscompares++;
      $display("FAIL midload_async_reset got=%b_%h_%h required=110000_0000_0000",
               {in_ready, busy, write_en_ir, start, done, error}, iram_addr, instruc_mem_store);
    end
    @(posedge clock); #1 reset = 1'b0;
    mark();
    fw[0] = 16'h1234; fw[1] = 16'hABCD; fw[2] = 16'h00FF;
    send_frame(16'd2, 16'd1, 3, 1'b0);
    cycles(3);
    vectors++;
    if (ir_n - ib !== 2 || dr_n - db !== 1) begin
      miscompares++;
      $display("FAIL b2b_counts iram=%0d dram=%0d required iram=2 dram=1", ir_n - ib, dr_n - db);
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (ir_a[ib+i] !== 16'(i) || ir_w[ib+i] !== fw[i] || ir_c[ib+i] !== exp_c[i]) begin
        miscompares++;
        $display("FAIL b2b_iram[%0d] addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                 i, ir_a[ib+i], ir_w[ib+i], ir_c[ib+i], 16'(i), fw[i], exp_c[i]);
      end
    end
    vectors++;
    if (dr_a[db] !== 16'h0000 || dr_w[db] !== 16'h00FF || dr_c[db] !== exp_c[2]) begin
      miscompares++;
      $display("FAIL b2b_dram addr=%h data=%h cyc=%0d required addr=0000 data=00ff cyc=%0d",
               dr_a[db], dr_w[db], dr_c[db], exp_c[2]);
    end
    vectors++;
    if (st_n - sb !== 1 || st_c[sb] !== exp_c[2] + 1) begin
      miscompares++;
      $display("FAIL b2b_start count=%0d cyc=%0d required count=1 cyc=%0d", st_n - sb, st_c[sb], exp_c[2] + 1);
    end
    vectors++;
    if (exp_c[1] - exp_c[0] !== 2 || exp_c[2] - exp_c[1] !== 2) begin
      miscompares++;
      $display("FAIL b2b_rate spacing=%0d,%0d required 2,2", exp_c[1] - exp_c[0], exp_c[2] - exp_c[1]);
    end
    vectors++;
    if ({done, busy, in_ready, start, error} !== 5'b10000 || both !== 0) begin
      miscompares++;
      $display("FAIL b2b_done flags=%b overlap=%0d required flags=10000 overlap=0",
               {done, busy, in_ready, start, error}, both);
    end
  endtask
  task automatic test_rearm;
    pulse_rearm();
    vectors++;
    if ({done, busy, in_ready} !== 3'b011) begin
      miscompares++;
      $display("FAIL rearm_done flags=%b required 011", {done, busy, in_ready});
    end
    mark();
    fw[0] = 16'h5555;
    send_frame(16'd1, 16'd0, 1, 1'b0);
    cycles(3);
    vectors++;
    if (ir_n - ib !== 1 || dr_n - db !== 0 || ir_a[ib] !== 16'h0000 || ir_w[ib] !== 16'h5555 || ir_c[ib] !== exp_c[0]) begin
      miscompares++;
      $display("FAIL rearm_write n=%0d/%0d addr=%h data=%h cyc=%0d required n=1/0 addr=0000 data=5555 cyc=%0d",
               ir_n - ib, dr_n - db, ir_a[ib], ir_w[ib], ir_c[ib], exp_c[0]);
    end
    vectors++;
    if (st_n - sb !== 1 || st_c[sb] !== exp_c[0] + 1 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL rearm_start count=%0d cyc=%0d done=%b required count=1 cyc=%0d done=1",
               st_n - sb, st_c[sb], done, exp_c[0] + 1);
    end
  endtask
  task automatic test_gapped;
    pulse_rearm();
    mark();
    fw[0] = 16'h1234; fw[1] = 16'hABCD; fw[2] = 16'h00FF;
    send_frame(16'd2, 16'd1, 3, 1'b1);
    cycles(3);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (ir_a[ib+i] !== 16'(i) || ir_w[ib+i] !== fw[i] || ir_c[ib+i] !== exp_c[i]) begin
        miscompares++;
        $display("FAIL gap_iram[%0d] addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                 i, ir_a[ib+i], ir_w[ib+i], ir_c[ib+i], 16'(i), fw[i], exp_c[i]);
      end
    end
    vectors++;
    if (ir_n - ib !== 2 || dr_n - db !== 1 || dr_a[db] !== 16'h0000 || dr_w[db] !== 16'h00FF || dr_c[db] !== exp_c[2]) begin
      miscompares++;
      $display("FAIL gap_dram n=%0d/%0d addr=%h data=%h cyc=%0d required n=2/1 addr=0000 data=00ff cyc=%0d",
               ir_n - ib, dr_n - db, dr_a[db], dr_w[db], dr_c[db], exp_c[2]);
    end
    vectors++;
    if (exp_c[1] - exp_c[0] !== 4 || st_n - sb !== 1 || st_c[sb] !== exp_c[2] + 1 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_timing spacing=%0d starts=%0d cyc=%0d done=%b required spacing=4 starts=1 cyc=%0d done=1",
               exp_c[1] - exp_c[0], st_n - sb, st_c[sb], done, exp_c[2] + 1);
    end
  endtask
  task automatic test_empty;
    pulse_rearm();
    mark();
    send_frame(16'd0, 16'd0, 0, 1'b0);
    cycles(2);
    vectors++;
    if (ir_n - ib !== 0 || dr_n - db !== 0) begin
      miscompares++;
      $display("FAIL empty_writes iram=%0d dram=%0d required 0 0", ir_n - ib, dr_n - db);
    end
    vectors++;
    if (st_n - sb !== 1 || st_c[sb] !== acc_c || done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_start count=%0d cyc=%0d done=%b busy=%b required count=1 cyc=%0d done=1 busy=0",
               st_n - sb, st_c[sb], done, busy, acc_c);
    end
  endtask
  task automatic test_overflow;
    pulse_rearm();
    mark();
    send_frame(16'd257, 16'd0, 0, 1'b0);
    cycles(1);
    vectors++;
    if ({error, in_ready, busy, done, start} !== 5'b10000) begin
      miscompares++;
      $display("FAIL ovf_ni_flags got=%b required=10000", {error, in_ready, busy, done, start});
    end
    in_data = 8'hAA; in_valid = 1'b1;
    cycles(4);
    in_valid = 1'b0;
    vectors++;
    if (error !== 1'b1 || ir_n - ib !== 0 || dr_n - db !== 0 || st_n - sb !== 0) begin
      miscompares++;
      $display("FAIL ovf_ni_quiet error=%b writes=%0d/%0d starts=%0d required error=1 writes=0/0 starts=0",
               error, ir_n - ib, dr_n - db, st_n - sb);
    end
    pulse_rearm();
    vectors++;
    if ({error, in_ready, busy} !== 3'b011) begin
      miscompares++;
      $display("FAIL ovf_rearm got=%b required=011", {error, in_ready, busy});
    end
    send_frame(16'd0, 16'd257, 0, 1'b0);
    cycles(1);
    vectors++;
    if ({error, in_ready, busy, st_n - sb} !== {3'b100, 32'd0}) begin
      miscompares++;
      $display("FAIL ovf_nd error=%b in_ready=%b busy=%b starts=%0d required 1 0 0 0", error, in_ready, busy, st_n - sb);
    end
    pulse_rearm();
  endtask
  task automatic test_reset_mid_word;
    mark();
    fw[0] = 16'hBEEF;
    send_frame(16'd2, 16'd0, 1, 1'b0);
    send(8'hCA, 1'b0);
    vectors++;
    if (ir_n - ib !== 1 || ir_w[ib] !== 16'hBEEF || ir_a[ib] !== 16'h0000) begin
      miscompares++;
      $display("FAIL midword_first n=%0d data=%h addr=%h required n=1 data=beef addr=0000", ir_n - ib, ir_w[ib], ir_a[ib]);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({in_ready, busy, write_en_ir, instruc_mem_store, iram_addr} !== {3'b110, 32'd0}) begin
      miscompares++;
      $display("FAIL midword_async_reset got=%b_%h_%h required=110_0000_0000",
               {in_ready, busy, write_en_ir}, instruc_mem_store, iram_addr);
    end
    @(posedge clock); #1 reset = 1'b0;
    mark();
    fw[0] = 16'h0A0B; fw[1] = 16'hC0DE;
    send_frame(16'd1, 16'd1, 2, 1'b0);
    cycles(3);
    vectors++;
    if (ir_n - ib !== 1 || ir_a[ib] !== 16'h0000 || ir_w[ib] !== 16'h0A0B || ir_c[ib] !== exp_c[0]) begin
      miscompares++;
      $display("FAIL midword_iram n=%0d addr=%h data=%h cyc=%0d required n=1 addr=0000 data=0a0b cyc=%0d",
               ir_n - ib, ir_a[ib], ir_w[ib], ir_c[ib], exp_c[0]);
    end
    vectors++;
    if (dr_n - db !== 1 || dr_a[db] !== 16'h0000 || dr_w[db] !== 16'hC0DE || st_n - sb !== 1 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL midword_dram n=%0d addr=%h data=%h starts=%0d done=%b required n=1 addr=0000 data=c0de starts=1 done=1",
               dr_n - db, dr_a[db], dr_w[db], st_n - sb, done);
    end
  endtask
  initial begin
    test_reset();
    test_reset_mid_load();
    test_rearm();
    test_gapped();
    test_empty();
    test_overflow();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required completion before 200000", $time);
    $fatal(1);
  end
endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Upstream stage of the processor top level.
- Receives a byte stream from a serial receiver over a valid/ready handshake and assembles the bytes into 16-bit words.
- Writes those words into instruction RAM, then data RAM, through the same data/write-enable ports the memories use.
- Then issues the start pulse to the core and owns the memory address buses until loading is complete.

Parameters:
- DATA_W, 16, memory word width; always two bytes per word.
- ADDR_W, 16, width of the memory address outputs.
- IRAM_DEPTH, 256, instruction words accepted; a larger header count is an error.
- DRAM_DEPTH, 256, data words accepted; a larger header count is an error.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  received byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- rearm  input  1  from DONE or ERROR, begin a new load.
- instruc_mem_store  output  DATA_W  word to IRAM.
- write_en_ir  output  1  IRAM write strobe.
- iram_addr  output  ADDR_W  IRAM write address.
- data_mem_store  output  DATA_W  word to DRAM.
- write_en_d  output  1  DRAM write strobe.
- dram_addr  output  ADDR_W  DRAM write address.
- start  output  1  one-cycle start pulse to the core.
- busy  output  1  loader owns the memory buses; the top-level address mux selects the loader while high.
- done  output  1  load completed successfully.
- error  output  1  header count exceeded a depth parameter.

Behaviour:
- Reset (asynchronous, highest priority, also mid-load):
  - state = HDR_I_HI; all counters, addresses and the partial-word register cleared.
  - in_ready = 1, busy = 1.
  - write_en_ir = write_en_d = start = done = error = 0.
  - Data and address outputs = 0.
  - A partial word in progress is discarded.
- A byte is accepted when in_valid and in_ready are both high on a rising clock edge.
- Frame format, all fields big-endian (high byte first):
  - NI: 16-bit instruction word count.
  - ND: 16-bit data word count.
  - NI instruction words, then ND data words.
- States:
  - HDR_I_HI, HDR_I_LO: capture NI.
  - HDR_D_HI, HDR_D_LO: capture ND. On the HDR_D_LO accept:
    - NI > IRAM_DEPTH or ND > DRAM_DEPTH -> ERROR;
    - else NI != 0 -> LOAD_I;
    - else ND != 0 -> LOAD_D;
    - else -> START.
  - LOAD_I: hi/lo byte phase flag. On the lo-byte accept, the assembled word is written the following cycle:
    - instruc_mem_store = word, iram_addr = index, write_en_ir = 1 for exactly that one cycle;
    - index increments after the write;
    - after the NI-th word: ND != 0 -> LOAD_D, else -> START.
  - LOAD_D: identical to LOAD_I using data_mem_store, dram_addr, write_en_d and count ND; after the last word -> START.
  - START: in_ready = 0; start = 1 for exactly one cycle; busy falls in the same cycle -> DONE.
  - DONE: done = 1, busy = 0, in_ready = 0. rearm -> HDR_I_HI with counters cleared and done = 0.
  - ERROR: error = 1, busy = 0, in_ready = 0, no writes. rearm -> HDR_I_HI with error = 0.
- in_ready is high in all HDR and LOAD states; there are no internal stalls, so the loader sustains one byte per cycle.
- Write latency is 1 cycle from the lo-byte handshake to the strobe.
- When the final lo byte is accepted, the last write strobe and the transition to START happen in the same cycle; start is asserted the cycle after that.
- write_en_ir and write_en_d are never high in the same cycle.
- Addresses are zero-extended indices; the depth checks guarantee they never wrap.
- Bytes presented while in_ready = 0 are ignored and not consumed.
- rearm has no effect outside DONE and ERROR.

Test Plan:
- Reset mid-load, then a clean frame:
  - Stimulus: assert reset after 3 words of a load; then send NI=2, ND=1, IRAM words 0x1234, 0xABCD, DRAM word 0x00FF, back-to-back.
  - Response: writes IRAM[0]=0x1234, IRAM[1]=0xABCD, DRAM[0]=0x00FF, each 1 cycle after its lo byte; no writes from the interrupted frame; start pulses exactly once, then done = 1 and busy = 0.
- Gapped valid: the same frame with in_valid low on alternate cycles -> identical writes; only the timing stretches.
- NI=0, ND=0 -> no write strobes; start pulses 1 cycle after the ND low byte; then done = 1.
- NI=257 with IRAM_DEPTH=256 -> error = 1, no writes, no start, in_ready = 0; then pulse rearm -> error = 0, in_ready = 1, state HDR_I_HI.
- Reset asserted between the hi and lo byte of word 1 (IRAM[0] already written) -> outputs return to reset values immediately; the next frame writes from address 0 and the partial byte is never written.
- From DONE, pulse rearm and send NI=1, word 0x5555 -> IRAM[0]=0x5555, iram_addr=0 on the strobe; start pulses once more.
